arrow_key_decoder: RTL and testbench
====================================

# arrow_key_decoder

Parametrised successor to the single-cycle arrow selector. It synchronises and debounces N raw direction keys, then decodes a clean single-key press into a direction code. It emits a one-cycle press event plus a held direction level, and locks out multi-key chords until every key is released. It sits between the board push-buttons and the Simon Says game FSM, which consumes `press_valid`/`direction_out` as the player's move.

## Interface
- `NUM_KEYS`, 4: number of direction keys. Key index i maps to code i; with 4 keys: 0=UP, 1=RIGHT, 2=DOWN, 3=LEFT.
- `CODE_W`, 3: width of the direction code. Legal only if 2^CODE_W > NUM_KEYS; the all-ones code is reserved for NONE.
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles needed to accept a level change. Minimum 1.
- `KEY_ACTIVE_LOW`, 0: when 1, `keys_raw` is inverted before synchronisation (board KEYs).
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `keys_raw`  in  NUM_KEYS  asynchronous raw key inputs.
- `direction_out`  out  CODE_W  code of the current accepted key; NONE (all ones) otherwise.
- `press_valid`  out  1  one-cycle pulse on each accepted press.
- `multi_press`  out  1  high while in LOCKOUT.
- `keys_debounced`  out  NUM_KEYS  debounced active-high key levels (debug/LEDs).

## Operation
- Per key: a 2-flop synchroniser, then a debouncer. The counter increments each cycle the synchronised level differs from the stable level, and clears on any cycle the two are equal. When it reaches DEBOUNCE_CYCLES, the stable level flips and the counter clears.
- Decoder FSM on the `keys_debounced` vector:
  - IDLE: all keys released; `direction_out`=NONE.
    - Exactly one key high: go to PRESSED, load its index into `direction_out`, pulse `press_valid`.
    - Two or more keys high: go to LOCKOUT.
  - PRESSED: hold `direction_out`.
    - Vector all zero: go to IDLE, set `direction_out`=NONE.
    - Any additional key rises: go to LOCKOUT, set `direction_out`=NONE, no pulse.
  - LOCKOUT: `multi_press`=1, `direction_out`=NONE.
    - Vector all zero: go to IDLE.
    - One key remaining does not produce a press; a full release is always required.
- At most one `press_valid` per press/release cycle. Holding a key never repeats the pulse.
- Simultaneous events:
  - Two keys becoming stable in the same cycle from IDLE go to LOCKOUT.
  - Release of the held key and rise of another key in the same cycle from PRESSED count as multi-key, so the FSM goes to LOCKOUT.
- Reset, including mid-debounce or mid-press, clears synchronisers, counters and stable levels to released, and puts the FSM in IDLE. A key held through reset is re-debounced and generates a fresh press.

## Timing
- Reset values: `direction_out`=all ones, `press_valid`=0, `multi_press`=0, `keys_debounced`=0.
- Latency:
  - Edge 0 is the first edge that samples the new raw level.
  - `keys_debounced` changes at edge DEBOUNCE_CYCLES+1.
  - `press_valid`/`direction_out` update at edge DEBOUNCE_CYCLES+2.
- Release latency is the same: `direction_out` returns to NONE DEBOUNCE_CYCLES+2 edges after the raw release.
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles never change `keys_debounced`.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `arrow_pkg`:
  - direction localparams DIR_UP=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_LEFT=3;
  - DIR_NONE as all ones of CODE_W;
  - FSM state encodings IDLE/PRESSED/LOCKOUT.
- Sub-module `key_debounce`, parametrised by DEBOUNCE_CYCLES: synchroniser, counter and stable flop for one key. It is instantiated NUM_KEYS times via generate.
- Top level: input inversion, debouncer array, one-hot/popcount check, decoder FSM, output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and the default parameters.
- Reset then idle: `direction_out`=3'b111, `press_valid`=0, `multi_press`=0 for 20 cycles.
- Press RIGHT (`keys_raw`=4'b0010) and hold 30 cycles → exactly one `press_valid` pulse, 6 edges after the sampling edge; `direction_out`=3'b001 until 6 edges after release, then 3'b111.
- 3-cycle glitch on DOWN → `keys_debounced` stays 0, no pulse, `direction_out`=3'b111.
- UP and LEFT pressed together → `multi_press`=1, no pulse. Release LEFT only → still LOCKOUT. Release all → IDLE. Press LEFT again → one pulse with code 3'b011.
- Hold UP, then add DOWN → `direction_out` goes 3'b000 → 3'b111, `multi_press`=1, no second pulse.
- Assert `reset` mid-press while UP is still held → outputs return to reset values; after reset, one new pulse with code 3'b000 at the debounce latency.
- With `KEY_ACTIVE_LOW`=1 and `keys_raw`=4'b1011 → press decoded as DOWN (3'b010).

Source files
------------

// File: rtl/arrow_key_decoder_pkg.sv
// arrow_pkg: shared direction codes (UP/RIGHT/DOWN/LEFT, NONE) and decoder FSM state encoding
package arrow_pkg;
  localparam int DIR_UP = 0;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_DOWN = 2;
  localparam int DIR_LEFT = 3;
  localparam int DEF_CODE_W = 3;
  localparam logic [DEF_CODE_W-1:0] DIR_NONE = '1;
  typedef enum logic [1:0] {IDLE, PRESSED, LOCKOUT} state_t;
endpackage

// File: rtl/arrow_key_decoder_if.sv
// arrow_key_decoder_if: keys_raw in; direction_out/press_valid/multi_press/keys_debounced out (slave = decoder)
interface arrow_key_decoder_if #(
  parameter int NUM_KEYS = 4,
  parameter int CODE_W = 3
);
  logic [NUM_KEYS-1:0] keys_raw;
  logic [CODE_W-1:0] direction_out;
  logic press_valid;
  logic multi_press;
  logic [NUM_KEYS-1:0] keys_debounced;
  modport master(output keys_raw, input direction_out, press_valid, multi_press, keys_debounced);
  modport slave(input keys_raw, output direction_out, press_valid, multi_press, keys_debounced);
endinterface

// File: rtl/arrow_key_decoder_debounce.sv
// key_debounce: 2-flop synchroniser + stability counter for one key; ports clock, reset, i_key (raw), o_stable (debounced)
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_key,
  output logic o_stable
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] r_sync;
  logic [CW-1:0] r_cnt;
  logic r_stable;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= '0;
      r_cnt <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_key};
      if (r_sync[1] == r_stable) r_cnt <= '0;
      else if (r_cnt == LAST) begin
        r_stable <= r_sync[1];
        r_cnt <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_stable = r_stable;
endmodule

// File: rtl/arrow_key_decoder.sv
// arrow_key_decoder: debounces NUM_KEYS keys and decodes single presses; ports clock, reset, bus (slave: keys_raw in, direction/press/lockout/debounced out)
module arrow_key_decoder
  import arrow_pkg::*;
#(
  parameter int NUM_KEYS = 4,
  parameter int CODE_W = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int KEY_ACTIVE_LOW = 0
) (
  input logic clock,
  input logic reset,
  arrow_key_decoder_if.slave bus
);
  localparam logic [CODE_W-1:0] NONE = '1;
  logic [NUM_KEYS-1:0] w_keys, w_db, w_hot;
  logic [CODE_W-1:0] w_idx, r_dir;
  logic w_one, r_pv, r_mp;
  state_t r_state;
  assign w_keys = (KEY_ACTIVE_LOW != 0) ? ~bus.keys_raw : bus.keys_raw;
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock(clock),
      .reset(reset),
      .i_key(w_keys[k]),
      .o_stable(w_db[k])
    );
  end
  assign w_one = (w_db != '0) && ((w_db & (w_db - 1'b1)) == '0);
  // expected vector while a single key is held; any other pattern means a chord
  assign w_hot = NUM_KEYS'(1) << r_dir;
  always_comb begin
    w_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) w_idx = w_db[i] ? CODE_W'(i) : w_idx;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_dir <= NONE;
      r_pv <= 1'b0;
      r_mp <= 1'b0;
    end else begin
      r_pv <= 1'b0;
      case (r_state)
        IDLE:
          if (w_one) begin
            r_state <= PRESSED;
            r_dir <= w_idx;
            r_pv <= 1'b1;
          end else if (w_db != '0) begin
            r_state <= LOCKOUT;
            r_mp <= 1'b1;
          end
        PRESSED:
          if (w_db == '0) begin
            r_state <= IDLE;
            r_dir <= NONE;
          end else if (w_db != w_hot) begin
            r_state <= LOCKOUT;
            r_dir <= NONE;
            r_mp <= 1'b1;
          end
        LOCKOUT:
          if (w_db == '0) begin
            r_state <= IDLE;
            r_mp <= 1'b0;
          end
        default: begin
          r_state <= IDLE;
          r_dir <= NONE;
          r_mp <= 1'b0;
        end
      endcase
    end
  end
  assign bus.direction_out = r_dir;
  assign bus.press_valid = r_pv;
  assign bus.multi_press = r_mp;
  assign bus.keys_debounced = w_db;
endmodule

// File: tb/tb_arrow_key_decoder.sv
// tb_arrow_key_decoder: table vectors, latency/reset sequences and random stimulus against a window-based reference model
module tb_arrow_key_decoder;
  import arrow_pkg::*;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] raw = '0;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  always #5 clk = ~clk;
  arrow_key_decoder_if #(.NUM_KEYS(4), .CODE_W(3)) bus_a ();
  arrow_key_decoder_if #(.NUM_KEYS(4), .CODE_W(3)) bus_b ();
  assign bus_a.keys_raw = raw;
  assign bus_b.keys_raw = ~raw;
  arrow_key_decoder #(.NUM_KEYS(4), .CODE_W(3), .DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(0)) dut_a (
    .clock(clk),
    .reset(reset),
    .bus(bus_a)
  );
  arrow_key_decoder #(.NUM_KEYS(4), .CODE_W(3), .DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1)) dut_b (
    .clock(clk),
    .reset(reset),
    .bus(bus_b)
  );
  logic [3:0] q[$];
  logic [3:0] m_db = '0;
  logic [2:0] m_dir = DIR_NONE;
  logic m_pv = 1'b0;
  logic m_lock = 1'b0;
  always @(posedge clk) begin
    logic [3:0] s;
    bit diff;
    m_pv = 1'b0;
    if (reset) begin
      q.delete();
      for (int i = 0; i < D + 2; i++) q.push_front(4'b0);
      m_db = '0;
      m_dir = DIR_NONE;
      m_lock = 1'b0;
    end else begin
      if (m_db == 4'b0) begin
        m_dir = DIR_NONE;
        m_lock = 1'b0;
      end else if (!m_lock) begin
        if (m_dir == DIR_NONE) begin
          if ($countones(m_db) == 1) begin
            m_dir = 3'($clog2(m_db));
            m_pv = 1'b1;
          end else m_lock = 1'b1;
        end else if (m_db != (4'b1 << m_dir)) begin
          m_lock = 1'b1;
          m_dir = DIR_NONE;
        end
      end
      q.push_front(raw);
      void'(q.pop_back());
      for (int k = 0; k < 4; k++) begin
        diff = 1'b1;
        for (int j = 2; j < D + 2; j++) begin
          s = q[j];
          if (s[k] == m_db[k]) diff = 1'b0;
        end
        if (diff) m_db[k] = ~m_db[k];
      end
    end
  end
  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cmp("dir_a", bus_a.direction_out, m_dir);
      cmp("pv_a", bus_a.press_valid, m_pv);
      cmp("mp_a", bus_a.multi_press, m_lock);
      cmp("db_a", bus_a.keys_debounced, m_db);
      cmp("dir_b", bus_b.direction_out, m_dir);
      cmp("pv_b", bus_b.press_valid, m_pv);
      cmp("mp_b", bus_b.multi_press, m_lock);
      cmp("db_b", bus_b.keys_debounced, m_db);
      if (bus_a.press_valid) pulses++;
    end
  endtask
  typedef struct {
    logic [3:0] raw;
    int cyc;
    logic [2:0] dir;
    int np;
    logic mp;
    logic [3:0] db;
  } vec_t;
  initial begin
    vec_t tbl[$];
    tbl.push_back('{4'b0000, 20, 3'b111, 0, 1'b0, 4'b0000});
    tbl.push_back('{4'b0010, 30, 3'b001, 1, 1'b0, 4'b0010});
    tbl.push_back('{4'b0000, 10, 3'b111, 0, 1'b0, 4'b0000});
    tbl.push_back('{4'b0100, 3, 3'b111, 0, 1'b0, 4'b0000});
    tbl.push_back('{4'b0000, 10, 3'b111, 0, 1'b0, 4'b0000});
    tbl.push_back('{4'b1001, 10, 3'b111, 0, 1'b1, 4'b1001});
    tbl.push_back('{4'b0001, 10, 3'b111, 0, 1'b1, 4'b0001});
    tbl.push_back('{4'b0000, 10, 3'b111, 0, 1'b0, 4'b0000});
    tbl.push_back('{4'b1000, 10, 3'b011, 1, 1'b0, 4'b1000});
    tbl.push_back('{4'b0000, 10, 3'b111, 0, 1'b0, 4'b0000});
    tbl.push_back('{4'b0001, 10, 3'b000, 1, 1'b0, 4'b0001});
    tbl.push_back('{4'b0101, 10, 3'b111, 0, 1'b1, 4'b0101});
    tbl.push_back('{4'b0000, 10, 3'b111, 0, 1'b0, 4'b0000});
    tbl.push_back('{4'b0100, 10, 3'b010, 1, 1'b0, 4'b0100});
    tbl.push_back('{4'b0000, 10, 3'b111, 0, 1'b0, 4'b0000});
    tbl.push_back('{4'b0001, 10, 3'b000, 1, 1'b0, 4'b0001});
    tbl.push_back('{4'b0100, 10, 3'b111, 0, 1'b1, 4'b0100});
    tbl.push_back('{4'b0000, 10, 3'b111, 0, 1'b0, 4'b0000});
    tick(3);
    cmp("rst_dir", bus_a.direction_out, 3'b111);
    cmp("rst_pv", bus_a.press_valid, 1'b0);
    cmp("rst_mp", bus_a.multi_press, 1'b0);
    cmp("rst_db", bus_a.keys_debounced, 4'b0);
    reset = 1'b0;
    foreach (tbl[i]) begin
      raw = tbl[i].raw;
      pulses = 0;
      tick(tbl[i].cyc);
      cmp($sformatf("v%0d_dir", i), bus_a.direction_out, tbl[i].dir);
      cmp($sformatf("v%0d_dirb", i), bus_b.direction_out, tbl[i].dir);
      cmp($sformatf("v%0d_pulses", i), pulses, tbl[i].np);
      cmp($sformatf("v%0d_mp", i), bus_a.multi_press, tbl[i].mp);
      cmp($sformatf("v%0d_db", i), bus_a.keys_debounced, tbl[i].db);
    end
    raw = 4'b0010;
    pulses = 0;
    for (int e = 0; e <= D + 2; e++) begin
      tick(1);
      cmp($sformatf("lat_pv_e%0d", e), bus_a.press_valid, e == D + 2);
      cmp($sformatf("lat_dir_e%0d", e), bus_a.direction_out, (e == D + 2) ? 3'b001 : 3'b111);
    end
    tick(30);
    cmp("hold_pulses", pulses, 1);
    raw = 4'b0000;
    for (int e = 0; e <= D + 2; e++) begin
      tick(1);
      cmp($sformatf("rel_dir_e%0d", e), bus_a.direction_out, (e == D + 2) ? 3'b111 : 3'b001);
    end
    tick(5);
    raw = 4'b0001;
    tick(10);
    cmp("mid_dir", bus_a.direction_out, 3'b000);
    reset = 1'b1;
    tick(1);
    cmp("mrst_dir", bus_a.direction_out, 3'b111);
    cmp("mrst_pv", bus_a.press_valid, 1'b0);
    cmp("mrst_mp", bus_a.multi_press, 1'b0);
    cmp("mrst_db", bus_a.keys_debounced, 4'b0);
    tick(2);
    reset = 1'b0;
    pulses = 0;
    for (int e = 0; e <= D + 2; e++) begin
      tick(1);
      cmp($sformatf("rr_pv_e%0d", e), bus_a.press_valid, e == D + 2);
      cmp($sformatf("rr_dir_e%0d", e), bus_a.direction_out, (e == D + 2) ? 3'b000 : 3'b111);
    end
    tick(10);
    cmp("rr_pulses", pulses, 1);
    raw = 4'b0000;
    tick(10);
    for (int s = 0; s < 250; s++) begin
      int r;
      r = $urandom_range(0, 9);
      raw = (r < 5) ? 4'(1 << $urandom_range(0, 3)) : (r < 7) ? 4'b0 : 4'($urandom_range(0, 15));
      if (s % 60 == 59) begin
        reset = 1'b1;
        tick($urandom_range(1, 3));
        reset = 1'b0;
      end
      tick($urandom_range(1, 12));
    end
    raw = 4'b0000;
    tick(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
